// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store sequencer:
// register-write modes, store types, sequencer state and the
// alignment check used by the optional misalignment trap (MISALIGN_TRAP_EN).
package mem_access_unit_pkg;

   // Register-write mode carried down the pipeline to WB
   localparam logic [2:0] NOREGWRITE = 3'd0;
   localparam logic [2:0] LB         = 3'd1;
   localparam logic [2:0] LH         = 3'd2;
   localparam logic [2:0] LW         = 3'd3;
   localparam logic [2:0] LBU        = 3'd4;
   localparam logic [2:0] LHU        = 3'd5;

   // Store width requested by the M-stage instruction
   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_SB   = 2'd1;
   localparam logic [1:0] ST_SH   = 2'd2;
   localparam logic [1:0] ST_SW   = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mau_state_e;

   // True when the access cannot be served by a single naturally aligned word access.
   // A load takes precedence over a simultaneous store.
   function automatic logic is_misaligned(input logic       load,
                                          input logic [2:0] reg_write,
                                          input logic [1:0] store_type,
                                          input logic [1:0] byte_off);
      logic res;
      if (load) begin
         res = (((reg_write == LH) || (reg_write == LHU)) && byte_off[0]) ||
               ((reg_write == LW) && (byte_off != 2'b00));
      end else begin
         res = ((store_type == ST_SH) && byte_off[0]) ||
               ((store_type == ST_SW) && (byte_off != 2'b00));
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Store lane generator: byte enables and lane-replicated write data
// for SB/SH/SW at a given byte offset within the word.
module mem_access_unit_store_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  store_type,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   output logic [3:0]  we,
   output logic [31:0] wdata
);

   // Select enables and replicate the stored lane(s) across the word
   always_comb begin
      we    = 4'b0000;
      wdata = 32'h0000_0000;
      case (store_type)
         ST_SB: begin
            we    = 4'b0001 << byte_off;
            wdata = {4{store_data[7:0]}};
         end
         ST_SH: begin
            // shift in a 4-bit context so offset 3 truncates to 1000
            we    = 4'b0011 << byte_off;
            wdata = {2{store_data[15:0]}};
         end
         ST_SW: begin
            we    = 4'b1111;
            wdata = store_data;
         end
         default: begin
            we    = 4'b0000;
            wdata = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: issues a handshaked word access on the
// data-memory port, stalls the pipeline until it completes or times out,
// and registers the MEM/WB payload. Optional feature macro: MISALIGN_TRAP_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        LoadM,
   input  logic [1:0]  StoreTypeM,
   input  logic [2:0]  RegWriteM,
   input  logic [31:0] AluOutM,
   input  logic [31:0] StoreDataM,
   output logic        DmReq,
   output logic [31:0] DmAddr,
   output logic [3:0]  DmWe,
   output logic [31:0] DmWdata,
   input  logic        DmGnt,
   input  logic        DmRvalid,
   input  logic [31:0] DmRdata,
   output logic        StallM,
   output logic [2:0]  RegWriteW,
   output logic [1:0]  LoadedBytesSelectW,
   output logic [31:0] DmOutW,
   output logic        BusErrW,
   output logic        MisalignW
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   mau_state_e        state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0]       dm_addr_q, dm_addr_d;
   logic [3:0]        dm_we_q, dm_we_d;
   logic [31:0]       dm_wdata_q, dm_wdata_d;
   logic              is_load_q, is_load_d;
   logic              err_q, err_d;
   logic [2:0]        reg_write_w_q, reg_write_w_d;
   logic [1:0]        lbs_w_q, lbs_w_d;
   logic [31:0]       dm_out_w_q, dm_out_w_d;
   logic              bus_err_w_q, bus_err_w_d;
   logic              misalign_w_q, misalign_w_d;

   logic              stall_s;
   logic              mem_op_s;
   logic              misalign_s;
   logic              timeout_s;
   logic [3:0]        align_we_s;
   logic [31:0]       align_wdata_s;

   mem_access_unit_store_align u_store_align (
      .store_type (StoreTypeM),
      .byte_off   (AluOutM[1:0]),
      .store_data (StoreDataM),
      .we         (align_we_s),
      .wdata      (align_wdata_s)
   );

`ifdef MISALIGN_TRAP_EN
   assign misalign_s = (state_q == IDLE) &&
                       is_misaligned(LoadM, RegWriteM, StoreTypeM, AluOutM[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   assign mem_op_s  = LoadM || (StoreTypeM != ST_NONE);
   assign timeout_s = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

   // Sequencer next state, latched request fields, wait counter and stall
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      dm_addr_d  = dm_addr_q;
      dm_we_d    = dm_we_q;
      dm_wdata_d = dm_wdata_q;
      is_load_d  = is_load_q;
      err_d      = err_q;
      dm_out_w_d = dm_out_w_q;
      stall_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op_s && !misalign_s) begin
               stall_s    = 1'b1;
               state_d    = REQ;
               wait_cnt_d = {CNT_W{1'b0}};
               err_d      = 1'b0;
               is_load_d  = LoadM;
               dm_addr_d  = {AluOutM[31:2], 2'b00};
               // a load wins over a simultaneous store
               dm_we_d    = LoadM ? 4'b0000 : align_we_s;
               dm_wdata_d = LoadM ? 32'h0000_0000 : align_wdata_s;
            end else begin
               stall_s = 1'b0;
            end
         end
         REQ: begin
            stall_s    = 1'b1;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (DmGnt) begin
               state_d = is_load_q ? WAIT : DONE;
            end else if (timeout_s) begin
               state_d    = DONE;
               err_d      = 1'b1;
               dm_out_w_d = 32'h0000_0000;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            stall_s    = 1'b1;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (DmRvalid) begin
               state_d    = DONE;
               dm_out_w_d = DmRdata;
            end else if (timeout_s) begin
               state_d    = DONE;
               err_d      = 1'b1;
               dm_out_w_d = 32'h0000_0000;
            end else begin
               state_d = WAIT;
            end
         end
         DONE: begin
            stall_s = 1'b0;
            state_d = IDLE;
         end
         default: begin
            stall_s = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // MEM/WB payload: bubble while stalled, abort/trap flags for one cycle
   always_comb begin
      if (stall_s) begin
         reg_write_w_d = NOREGWRITE;
         lbs_w_d       = lbs_w_q;
         bus_err_w_d   = 1'b0;
         misalign_w_d  = 1'b0;
      end else begin
         bus_err_w_d   = (state_q == DONE) && err_q;
         misalign_w_d  = misalign_s;
         reg_write_w_d = (bus_err_w_d || misalign_s) ? NOREGWRITE : RegWriteM;
         lbs_w_d       = AluOutM[1:0];
      end
   end

   // State and payload registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wait_cnt_q    <= {CNT_W{1'b0}};
         dm_addr_q     <= 32'h0000_0000;
         dm_we_q       <= 4'b0000;
         dm_wdata_q    <= 32'h0000_0000;
         is_load_q     <= 1'b0;
         err_q         <= 1'b0;
         reg_write_w_q <= NOREGWRITE;
         lbs_w_q       <= 2'b00;
         dm_out_w_q    <= 32'h0000_0000;
         bus_err_w_q   <= 1'b0;
         misalign_w_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         dm_addr_q     <= dm_addr_d;
         dm_we_q       <= dm_we_d;
         dm_wdata_q    <= dm_wdata_d;
         is_load_q     <= is_load_d;
         err_q         <= err_d;
         reg_write_w_q <= reg_write_w_d;
         lbs_w_q       <= lbs_w_d;
         dm_out_w_q    <= dm_out_w_d;
         bus_err_w_q   <= bus_err_w_d;
         misalign_w_q  <= misalign_w_d;
      end
   end

   assign DmReq              = (state_q == REQ);
   assign DmAddr             = dm_addr_q;
   assign DmWe               = dm_we_q;
   assign DmWdata            = dm_wdata_q;
   assign StallM             = stall_s;
   assign RegWriteW          = reg_write_w_q;
   assign LoadedBytesSelectW = lbs_w_q;
   assign DmOutW             = dm_out_w_q;
   assign BusErrW            = bus_err_w_q;
   assign MisalignW          = misalign_w_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store sequencer of the RV32I pipeline. Turns the EX/MEM load/store request into a handshaked word access on the data-memory port, stalling the pipeline until completion. Generates byte enables and lane-replicated store data, and registers the MEM/WB payload (raw loaded word, byte offset, load type) that feeds the WB-stage data extension logic.

## Interface
- MAX_WAIT, 15: cycles allowed in REQ or WAIT before the access is aborted as a bus error.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- LoadM  in  1  M-stage instruction is a load
- StoreTypeM  in  2  00 none, 01 SB, 10 SH, 11 SW
- RegWriteM  in  3  register-write mode (NOREGWRITE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5)
- AluOutM  in  32  effective byte address / ALU result
- StoreDataM  in  32  rs2 value for stores
- DmReq  out  1  memory request
- DmAddr  out  32  word address, bits [1:0] = 00
- DmWe  out  4  byte write enables (0000 for loads)
- DmWdata  out  32  lane-replicated store data
- DmGnt  in  1  request accepted this cycle
- DmRvalid  in  1  read data valid
- DmRdata  in  32  read word
- StallM  out  1  hold IF..MEM stages
- RegWriteW  out  3  registered write mode to WB
- LoadedBytesSelectW  out  2  registered AluOutM[1:0]
- DmOutW  out  32  registered raw loaded word
- BusErrW  out  1  one-cycle abort flag, aligned with the aborted instruction in WB
- MisalignW  out  1  one-cycle misalignment flag (0 unless MISALIGN_TRAP_EN)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if LoadM or StoreTypeM≠0, latch DmAddr={AluOutM[31:2],2'b00}, DmWe, DmWdata; go REQ. Otherwise stay.
- LoadM together with a store: load wins; store ignored.
- REQ: DmReq=1; address, enables and data are stable until DmGnt.
  - On DmGnt, a store goes DONE and a load goes WAIT.
- WAIT: on DmRvalid, capture DmRdata into DmOutW; go DONE.
  - DmRvalid seen in REQ is ignored.
- DONE: StallM=0; go IDLE.
- Timeout: wait counter cleared on entry to REQ and counts in REQ and WAIT. On reaching MAX_WAIT:
  - drop DmReq;
  - go DONE with BusErrW=1, DmOutW=0, RegWriteW=NOREGWRITE.
- Store lanes:
  - SB: DmWe=0001<<AluOutM[1:0], DmWdata={4{StoreDataM[7:0]}}.
  - SH: DmWe=0011<<AluOutM[1:0] (truncated to 4 bits), DmWdata={2{StoreDataM[15:0]}}.
  - SW: DmWe=1111, DmWdata=StoreDataM.
- StallM=1 in IDLE with a memory op pending, and in REQ and WAIT.
- WB registers:
  - When StallM=0: RegWriteW←RegWriteM and LoadedBytesSelectW←AluOutM[1:0].
  - When StallM=1: RegWriteW←NOREGWRITE (bubble).
  - DmOutW is written only on DmRvalid or timeout.

## Timing
- Reset: state IDLE. DmReq, DmAddr, DmWe, DmWdata, StallM (no op pending), RegWriteW, LoadedBytesSelectW, DmOutW, BusErrW and MisalignW are all 0. The wait counter is 0.
- Reset mid-access abandons the access immediately; DmReq drops asynchronously.
- Store with DmGnt on the first REQ cycle: op at c0 (IDLE, stall), c1 REQ, c2 DONE. Instruction leaves MEM at the end of c2; 2 stall cycles.
- Load with gnt at c1 and rvalid at c2: DONE at c3. DmOutW is valid in WB from c4, together with RegWriteW/LoadedBytesSelectW.
- Non-memory ops pass with zero latency added and StallM=0.
- Back-to-back memory ops: the second enters IDLE the cycle after DONE.

## Configuration
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠00, issue no bus access and add no stall.
  - The instruction passes with RegWriteW=NOREGWRITE and MisalignW=1 for one cycle.
- MISALIGN_TRAP_EN undefined:
  - No check; MisalignW tied 0.
  - Word accesses ignore addr[1:0].
  - SH enables are truncated (offset 3 → 1000).

## Structure
- Shared package/Parameters.v holds:
  - RegWrite encodings (NOREGWRITE..LHU);
  - StoreType encodings;
  - FSM state encoding.
- Sub-module store_align: combinational generator of DmWe/DmWdata from StoreTypeM, AluOutM[1:0] and StoreDataM.

## Test plan
- SB, AluOutM=0x1003, StoreDataM=0xAABBCCDD, gnt immediate → DmAddr=0x1000, DmWe=1000, DmWdata=0xDDDDDDDD, StallM high 2 cycles.
- LW at 0x2000, gnt at REQ+0, rvalid 3 cycles later with 0x12345678 → DmOutW=0x12345678, RegWriteW=LW, LoadedBytesSelectW=00, StallM released exactly at DONE.
- LBU at 0x2002 followed by ADD → LoadedBytesSelectW=10; ADD reaches WB one cycle after the load, with no bubble between them.
- DmGnt never asserted, MAX_WAIT=15 → DmReq drops after 15 REQ cycles, BusErrW=1 for one cycle, RegWriteW=0.
- With MISALIGN_TRAP_EN, LW at 0x2001 → DmReq never asserted, StallM=0, MisalignW=1, RegWriteW=0. Without it → DmAddr=0x2000 and the load completes normally.
- rst_n low while in WAIT → DmReq=0 and StallM=0 immediately; a stray DmRvalid after reset is ignored.
